// File: rtl/vdp2_fifo_pkg.sv
// Shared types and helpers for the VDP2 parametrised FIFO family.
// Sizing helpers and the packed status word returned by the FIFO top.
package vdp2_fifo_pkg;

   localparam int DEF_DW = 36;
   localparam int DEF_AW = 3;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result = result + 1;
      return result;
   endfunction

   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
      logic ovf;
      logic udf;
   } fifo_status_t;

endpackage

// File: rtl/vdp2_fifo_mem.sv
// DEPTH x DW storage for the VDP2 FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; only the pointers give the words meaning.
module vdp2_fifo_mem
   import vdp2_fifo_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int DEPTH = fifo_depth(AW);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vdp2_param_fifo.sv
// Parametrised single-clock FIFO buffering VDP2 register/VRAM write requests.
// Showahead or registered read, fill count, thresholds, flush, sticky errors.
module vdp2_param_fifo
   import vdp2_fifo_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int AW        = DEF_AW,
   parameter int SHOWAHEAD = 1,
   parameter int AF_LEVEL  = (1 << AW) - 2,
   parameter int AE_LEVEL  = 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          SCLR,
   input  logic [DW-1:0] DATA,
   input  logic          WRREQ,
   input  logic          RDREQ,
   output logic [DW-1:0] Q,
   output logic          EMPTY,
   output logic          FULL,
   output logic          ALMOST_EMPTY,
   output logic          ALMOST_FULL,
   output logic [AW:0]   USEDW,
   output logic          OVF,
   output logic          UDF
);

   localparam int DEPTH = fifo_depth(AW);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          r_ovf;
   logic          r_udf;

   logic          w_wr_ok;
   logic          w_rd_ok;
   logic          w_mem_we;
   logic [DW-1:0] w_rdata;
   fifo_status_t  w_status;

   // Handshake: WRREQ/RDREQ are requests sampled every rising edge, no
   // hold-off. A write is taken when not FULL, or when FULL with a same-cycle
   // read (the read frees the slot). A read is taken only when not EMPTY, so
   // a word written into an empty FIFO is never bypassed to the reader.
   // Rejected requests only set the sticky OVF/UDF flags.
   assign w_wr_ok  = WRREQ & (~w_status.full | RDREQ);
   assign w_rd_ok  = RDREQ & ~w_status.empty;
   assign w_mem_we = w_wr_ok & ~SCLR;

   // Thresholds compare as signed ints so out-of-range levels saturate.
   always_comb begin
      w_status              = '0;
      w_status.empty        = (r_cnt == '0);
      w_status.full         = (r_cnt == CNT_FULL);
      w_status.almost_empty = (int'(r_cnt) <= AE_LEVEL);
      w_status.almost_full  = (int'(r_cnt) >= AF_LEVEL);
      w_status.ovf          = r_ovf;
      w_status.udf          = r_udf;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else if (SCLR) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_wr_ok) r_wp <= r_wp + 1'b1;
         if (w_rd_ok) r_rp <= r_rp + 1'b1;
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (WRREQ && !w_wr_ok) r_ovf <= 1'b1;
         if (RDREQ && !w_rd_ok) r_udf <= 1'b1;
      end
   end

   vdp2_fifo_mem #(
      .DW (DW),
      .AW (AW)
   ) u_mem (
      .i_clk   (CLK),
      .i_we    (w_mem_we),
      .i_waddr (r_wp),
      .i_wdata (DATA),
      .i_raddr (r_rp),
      .o_rdata (w_rdata)
   );

   generate
      if (SHOWAHEAD != 0) begin : g_showahead
         assign Q = w_rdata;
      end else begin : g_registered
         logic [DW-1:0] r_q;
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N)       r_q <= '0;
            else if (SCLR)    r_q <= '0;
            else if (w_rd_ok) r_q <= w_rdata;
         end
         assign Q = r_q;
      end
   endgenerate

   assign EMPTY        = w_status.empty;
   assign FULL         = w_status.full;
   assign ALMOST_EMPTY = w_status.almost_empty;
   assign ALMOST_FULL  = w_status.almost_full;
   assign USEDW        = r_cnt;
   assign OVF          = w_status.ovf;
   assign UDF          = w_status.udf;

endmodule

// File: tb/tb_vdp2_param_fifo.sv
// Bench for vdp2_param_fifo: showahead and registered-read instances share
// stimulus; a queue model predicts contents, flags and both Q views.
module tb_vdp2_param_fifo;

   localparam int DW    = 36;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          CLK;
   logic          RST_N;
   logic          SCLR;
   logic [DW-1:0] DATA;
   logic          WRREQ;
   logic          RDREQ;

   logic [DW-1:0] q_s, q_n;
   logic          empty_s, full_s, ae_s, af_s, ovf_s, udf_s;
   logic          empty_n, full_n, ae_n, af_n, ovf_n, udf_n;
   logic [AW:0]   usedw_s, usedw_n;

   vdp2_param_fifo #(.DW(DW), .AW(AW), .SHOWAHEAD(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .SCLR(SCLR), .DATA(DATA), .WRREQ(WRREQ), .RDREQ(RDREQ),
      .Q(q_s), .EMPTY(empty_s), .FULL(full_s), .ALMOST_EMPTY(ae_s), .ALMOST_FULL(af_s),
      .USEDW(usedw_s), .OVF(ovf_s), .UDF(udf_s)
   );

   vdp2_param_fifo #(.DW(DW), .AW(AW), .SHOWAHEAD(0)) dut_n (
      .CLK(CLK), .RST_N(RST_N), .SCLR(SCLR), .DATA(DATA), .WRREQ(WRREQ), .RDREQ(RDREQ),
      .Q(q_n), .EMPTY(empty_n), .FULL(full_n), .ALMOST_EMPTY(ae_n), .ALMOST_FULL(af_n),
      .USEDW(usedw_n), .OVF(ovf_n), .UDF(udf_n)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic [AW:0]   cnt;
      logic          ovf;
      logic          udf;
      logic          head_v;
      logic [DW-1:0] head;
      logic [DW-1:0] qn;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] m_q[$];
   logic          m_ovf, m_udf;
   logic [DW-1:0] m_qn;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Immediate reset-value checks while RST_N is held low.
   task automatic chk_reset_values();
      chk("rst_usedw_s", 64'(usedw_s), 64'd0);
      chk("rst_usedw_n", 64'(usedw_n), 64'd0);
      chk("rst_empty",   64'(empty_s), 64'd1);
      chk("rst_full",    64'(full_s),  64'd0);
      chk("rst_ae",      64'(ae_s),    64'd1);
      chk("rst_af",      64'(af_s),    64'd0);
      chk("rst_ovf",     64'(ovf_s),   64'd0);
      chk("rst_udf",     64'(udf_s),   64'd0);
      chk("rst_q_n",     64'(q_n),     64'd0);
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d, input logic sclr);
      exp_t e;
      logic wr_ok, rd_ok;
      WRREQ = wr; RDREQ = rd; DATA = d; SCLR = sclr;
      if (sclr) begin
         m_q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_qn = '0;
      end else begin
         wr_ok = wr && ((m_q.size() < DEPTH) || rd);
         rd_ok = rd && (m_q.size() > 0);
         if (wr && !wr_ok) m_ovf = 1'b1;
         if (rd && !rd_ok) m_udf = 1'b1;
         if (rd_ok) m_qn = m_q.pop_front();
         if (wr_ok) m_q.push_back(d);
      end
      e.cnt    = (AW+1)'(m_q.size());
      e.ovf    = m_ovf;
      e.udf    = m_udf;
      e.head_v = (m_q.size() > 0);
      e.head   = (m_q.size() > 0) ? m_q[0] : '0;
      e.qn     = m_qn;
      exp_q.push_back(e);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #1;
      chk_reset_values();
      m_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_qn = '0;
      @(posedge CLK);
      @(negedge CLK);
      WRREQ = 1'b0; RDREQ = 1'b0; SCLR = 1'b0;
      RST_N = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("usedw_s", 64'(usedw_s), 64'(e.cnt));
            chk("usedw_n", 64'(usedw_n), 64'(e.cnt));
            chk("empty",   64'(empty_s), 64'(e.cnt == 0));
            chk("full",    64'(full_s),  64'(e.cnt == DEPTH));
            chk("almost_empty", 64'(ae_s), 64'(e.cnt <= 1));
            chk("almost_full",  64'(af_s), 64'(e.cnt >= DEPTH - 2));
            chk("ovf",     64'(ovf_s),   64'(e.ovf));
            chk("udf",     64'(udf_s),   64'(e.udf));
            chk("ovf_n",   64'(ovf_n),   64'(e.ovf));
            chk("udf_n",   64'(udf_n),   64'(e.udf));
            if (e.head_v) chk("q_showahead", 64'(q_s), 64'(e.head));
            chk("q_registered", 64'(q_n), 64'(e.qn));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] d;
      RST_N = 1'b0; SCLR = 1'b0; WRREQ = 1'b0; RDREQ = 1'b0; DATA = '0;
      m_ovf = 1'b0; m_udf = 1'b0; m_qn = '0;
      #1;
      chk_reset_values();
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      // fill then drain
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
      for (int i = 0; i < DEPTH; i++)  step(1'b0, 1'b1, '0, 1'b0);

      // overflow: rejected write, then write accepted alongside a read
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
      step(1'b1, 1'b0, DW'('hAAA), 1'b0);
      step(1'b1, 1'b1, DW'('hBBB), 1'b0);
      for (int i = 0; i < DEPTH; i++)  step(1'b0, 1'b1, '0, 1'b0);

      // read while empty with simultaneous write, then consume it
      step(1'b1, 1'b1, DW'('h55), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);

      // flush with a write present: write dropped, errors cleared
      step(1'b1, 1'b0, DW'('h77), 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);

      // wrap: 20 words streamed at a steady fill of 3
      for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, DW'('h100 + i), 1'b0);
      for (int i = 3; i < 20; i++) step(1'b1, 1'b1, DW'('h100 + i), 1'b0);
      for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, '0, 1'b0);

      // registered-read latency, rejected read holds Q
      step(1'b1, 1'b0, DW'('h7), 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);

      // asynchronous reset with 5 entries mid-stream
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'('h200 + i), 1'b0);
      WRREQ = 1'b1; DATA = DW'('h2FF);
      #2;
      do_reset();
      step(1'b0, 1'b0, '0, 1'b0);

      // randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         d = {4'($urandom_range(0, 15)), 32'($urandom())};
         step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), d,
              1'($urandom_range(0, 59) == 0));
      end

      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      @(posedge CLK);
      #2;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
